// File: rtl/lms_ctrl_pkg.sv
// Shared types and default parameters for the LMS frame sequencer.
// Optional gap-timeout build switch: LMS_FRAME_CTRL_TIMEOUT_EN.
package lms_ctrl_pkg;

    localparam int              DW_DEF      = 14;
    localparam int              NTAPS_DEF   = 32;
    localparam logic [13:0]     HEADER_DEF  = 14'h0FFF;
    localparam int              GAP_MAX_DEF = 2048;
    localparam int              TAP_W       = $clog2(NTAPS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_X = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_CLR    = 3'd3,
        ST_FILTER = 3'd4,
        ST_ERR    = 3'd5,
        ST_UPDATE = 3'd6
    } state_t;

endpackage

// File: rtl/lms_frame_ctrl_if.sv
// Word-stream input and datapath control bundle of the LMS frame sequencer.
interface lms_frame_ctrl_if #(
    parameter int DW    = 14,
    parameter int NTAPS = 32
);
    localparam int TW = $clog2(NTAPS);

    logic           word_vld;
    logic [DW-1:0]  word_data;
    logic [DW-1:0]  x_out;
    logic [DW-1:0]  d_out;
    logic [TW-1:0]  tap_idx;
    logic           mac_clr;
    logic           mac_en;
    logic           err_en;
    logic           upd_en;
    logic           head_flag;
    logic           busy;
    logic           frame_err;
    logic [15:0]    frame_cnt;

    modport master (
        output word_vld, word_data,
        input  x_out, d_out, tap_idx, mac_clr, mac_en, err_en, upd_en,
               head_flag, busy, frame_err, frame_cnt
    );

    modport slave (
        input  word_vld, word_data,
        output x_out, d_out, tap_idx, mac_clr, mac_en, err_en, upd_en,
               head_flag, busy, frame_err, frame_cnt
    );
endinterface

// File: rtl/lms_gap_timer.sv
// Inter-word gap counter: reloads on load, counts while enabled, flags expiry
// on the GAP_MAX-th consecutive enabled cycle without a reload.
import lms_ctrl_pkg::*;

module lms_gap_timer #(
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int            CW   = $clog2(GAP_MAX);
    localparam logic [CW-1:0] LAST = CW'(GAP_MAX - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign expired = en && !load && (cnt_r == LAST);

    // Idle-cycle counter, saturating at the expiry value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/lms_frame_ctrl.sv
// Frame parser and MAC/error/update sequencer for a 32-tap LMS filter datapath.
// Build switch LMS_FRAME_CTRL_TIMEOUT_EN enables the inter-word gap timeout.
import lms_ctrl_pkg::*;

module lms_frame_ctrl #(
    parameter int          DW     = DW_DEF,
    parameter int          NTAPS  = NTAPS_DEF,
    parameter logic [13:0] HEADER = HEADER_DEF
`ifdef LMS_FRAME_CTRL_TIMEOUT_EN
    ,
    parameter int          GAP_MAX = GAP_MAX_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst,
    lms_frame_ctrl_if.slave bus
);
    localparam int            TW       = $clog2(NTAPS);
    localparam logic [TW-1:0] TAP_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TAP_ONE  = TW'(1);
    localparam logic [TW-1:0] TAP_LAST = TW'(NTAPS - 1);

    state_t          state_r;
    logic [DW-1:0]   x_r;
    logic [DW-1:0]   d_r;
    logic [TW-1:0]   tap_idx_r;
    logic            mac_clr_r;
    logic            mac_en_r;
    logic            err_en_r;
    logic            upd_en_r;
    logic            head_flag_r;
    logic            busy_r;
    logic            frame_err_r;
    logic [15:0]     frame_cnt_r;
    logic            hdr_s;
    logic            gap_exp_s;

    assign hdr_s = (bus.word_data == DW'(HEADER));

`ifdef LMS_FRAME_CTRL_TIMEOUT_EN
    logic wait_s;
    logic gap_load_s;

    assign wait_s     = (state_r == ST_WAIT_X) || (state_r == ST_WAIT_D);
    assign gap_load_s = !wait_s || bus.word_vld;

    lms_gap_timer #(.GAP_MAX(GAP_MAX)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_load_s),
        .en      (wait_s),
        .expired (gap_exp_s)
    );
`else
    assign gap_exp_s = 1'b0;
`endif

    assign bus.x_out     = x_r;
    assign bus.d_out     = d_r;
    assign bus.tap_idx   = tap_idx_r;
    assign bus.mac_clr   = mac_clr_r;
    assign bus.mac_en    = mac_en_r;
    assign bus.err_en    = err_en_r;
    assign bus.upd_en    = upd_en_r;
    assign bus.head_flag = head_flag_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;
    assign bus.frame_cnt = frame_cnt_r;

    // Sequencer FSM; strobes default low and are raised alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            x_r         <= {DW{1'b0}};
            d_r         <= {DW{1'b0}};
            tap_idx_r   <= TAP_ZERO;
            mac_clr_r   <= 1'b0;
            mac_en_r    <= 1'b0;
            err_en_r    <= 1'b0;
            upd_en_r    <= 1'b0;
            head_flag_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            mac_clr_r   <= 1'b0;
            mac_en_r    <= 1'b0;
            err_en_r    <= 1'b0;
            upd_en_r    <= 1'b0;
            head_flag_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            tap_idx_r   <= TAP_ZERO;
            case (state_r)
                ST_IDLE: begin
                    if (bus.word_vld && hdr_s) begin
                        state_r <= ST_WAIT_X;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_X: begin
                    if (bus.word_vld && hdr_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_WAIT_X;
                    end else if (bus.word_vld) begin
                        x_r     <= bus.word_data;
                        state_r <= ST_WAIT_D;
                    end else if (gap_exp_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_X;
                    end
                end
                ST_WAIT_D: begin
                    if (bus.word_vld && hdr_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_WAIT_X;
                    end else if (bus.word_vld) begin
                        d_r       <= bus.word_data;
                        mac_clr_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_CLR;
                    end else if (gap_exp_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_D;
                    end
                end
                ST_CLR: begin
                    frame_err_r <= bus.word_vld;
                    busy_r      <= 1'b1;
                    mac_en_r    <= 1'b1;
                    state_r     <= ST_FILTER;
                end
                ST_FILTER: begin
                    frame_err_r <= bus.word_vld;
                    busy_r      <= 1'b1;
                    if (tap_idx_r == TAP_LAST) begin
                        err_en_r <= 1'b1;
                        state_r  <= ST_ERR;
                    end else begin
                        mac_en_r  <= 1'b1;
                        tap_idx_r <= tap_idx_r + TAP_ONE;
                        state_r   <= ST_FILTER;
                    end
                end
                ST_ERR: begin
                    frame_err_r <= bus.word_vld;
                    busy_r      <= 1'b1;
                    upd_en_r    <= 1'b1;
                    head_flag_r <= 1'b1;
                    state_r     <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    frame_err_r <= bus.word_vld;
                    if (tap_idx_r == TAP_LAST) begin
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        state_r     <= ST_IDLE;
                    end else begin
                        busy_r      <= 1'b1;
                        upd_en_r    <= 1'b1;
                        head_flag_r <= 1'b1;
                        tap_idx_r   <= tap_idx_r + TAP_ONE;
                        state_r     <= ST_UPDATE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lms_frame_ctrl.sv
// Directed, table-driven bench for lms_frame_ctrl; follows LMS_FRAME_CTRL_TIMEOUT_EN.
import lms_ctrl_pkg::*;

module tb_lms_frame_ctrl;
    localparam int N = NTAPS_DEF;

    typedef struct {
        logic [13:0] x;
        logic [13:0] d;
        int          gap;
        int          inj;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    lms_frame_ctrl_if #(.DW(DW_DEF), .NTAPS(NTAPS_DEF)) bus ();

    lms_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {mac_clr, mac_en, err_en, upd_en, head_flag, busy, frame_err, tap_idx}
    function automatic logic [11:0] obs();
        return {bus.mac_clr, bus.mac_en, bus.err_en, bus.upd_en, bus.head_flag,
                bus.busy, bus.frame_err, bus.tap_idx};
    endfunction

    // Expected control word k cycles after the d word was sampled.
    function automatic logic [11:0] exp_pat(input int k, input int inj);
        logic       clr, me, ee, ue, bz, fe;
        logic [4:0] t;
        clr = (k == 1);
        me  = (k >= 2) && (k <= N + 1);
        ee  = (k == N + 2);
        ue  = (k >= N + 3) && (k <= 2 * N + 2);
        bz  = (k >= 1) && (k <= 2 * N + 2);
        fe  = (inj > 0) && (k == inj + 1);
        t   = me ? 5'(k - 2) : (ue ? 5'(k - N - 3) : 5'd0);
        return {clr, me, ee, ue, ue, bz, fe, t};
    endfunction

    task automatic send_word(input logic [13:0] w, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.word_vld  = 1'b1;
        bus.word_data = w;
        @(negedge clk);
        bus.word_vld  = 1'b0;
        bus.word_data = 14'h0;
    endtask

    task automatic send_frame(input logic [13:0] x, input logic [13:0] d, input int gap);
        send_word(HEADER_DEF, gap);
        send_word(x, gap);
        send_word(d, gap);
    endtask

    // Walk the schedule cycle by cycle; inj>0 injects a header after cycle inj, stop_k>0 stops early.
    task automatic run_sched(input string name, input int inj, input int stop_k);
        for (int k = 1; k <= 2 * N + 3; k++) begin
            chk($sformatf("%s_k%0d", name, k), 32'(obs()), 32'(exp_pat(k, inj)));
            if (k == stop_k) break;
            if (k == inj) begin
                bus.word_vld  = 1'b1;
                bus.word_data = HEADER_DEF;
            end
            @(negedge clk);
            bus.word_vld  = 1'b0;
            bus.word_data = 14'h0;
        end
    endtask

    initial begin
        int seen;
        vecs[0] = '{x: 14'h0123, d: 14'h3F00, gap: 25, inj: 0,         cnt: 16'd1};
        vecs[1] = '{x: 14'h0000, d: 14'h3FFF, gap: 0,  inj: 0,         cnt: 16'd2};
        vecs[2] = '{x: 14'h2AAA, d: 14'h1555, gap: 3,  inj: 5,         cnt: 16'd3};
        vecs[3] = '{x: 14'h3FFF, d: 14'h0001, gap: 1,  inj: 2 * N + 2, cnt: 16'd4};

        bus.word_vld  = 1'b0;
        bus.word_data = 14'h0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'(obs()), 32'h0);
        chk("reset_x", 32'(bus.x_out), 32'h0);
        chk("reset_d", 32'(bus.d_out), 32'h0);
        chk("reset_cnt", 32'(bus.frame_cnt), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].x, vecs[v].d, vecs[v].gap);
            run_sched($sformatf("vec%0d", v), vecs[v].inj, 0);
            chk($sformatf("vec%0d_x", v), 32'(bus.x_out), 32'(vecs[v].x));
            chk($sformatf("vec%0d_d", v), 32'(bus.d_out), 32'(vecs[v].d));
            chk($sformatf("vec%0d_cnt", v), 32'(bus.frame_cnt), 32'(vecs[v].cnt));
        end

        // Header dropped in the last UPDATE cycle leaves the FSM idle.
        send_word(14'h0001, 0);
        send_word(14'h0002, 0);
        repeat (3) @(negedge clk);
        chk("drop_last_busy", 32'(bus.busy), 32'h0);
        chk("drop_last_x", 32'(bus.x_out), 32'h3FFF);

        // Resync on a header inside a frame.
        send_word(HEADER_DEF, 2);
        send_word(14'h0010, 2);
        chk("resync_pre_err", 32'(bus.frame_err), 32'h0);
        send_word(HEADER_DEF, 2);
        chk("resync_err", 32'(bus.frame_err), 32'h1);
        send_word(14'h0020, 2);
        chk("resync_post_err", 32'(bus.frame_err), 32'h0);
        send_word(14'h0030, 2);
        run_sched("resync", 0, 0);
        chk("resync_x", 32'(bus.x_out), 32'h0020);
        chk("resync_d", 32'(bus.d_out), 32'h0030);
        chk("resync_cnt", 32'(bus.frame_cnt), 32'd5);

        // Header followed by a long silence.
        send_word(HEADER_DEF, 2);
        seen = 0;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (bus.frame_err && (seen == 0)) seen = i;
        end
`ifdef LMS_FRAME_CTRL_TIMEOUT_EN
        chk("gap_expire_cycle", 32'(seen), 32'd2048);
        send_word(14'h0111, 0);
        send_word(14'h0222, 0);
        repeat (3) @(negedge clk);
        chk("gap_idle_busy", 32'(bus.busy), 32'h0);
        chk("gap_idle_x", 32'(bus.x_out), 32'h0020);
        send_frame(14'h0111, 14'h0222, 0);
        run_sched("gap_after", 0, 0);
`else
        chk("gap_no_expire", 32'(seen), 32'd0);
        send_word(14'h0111, 0);
        send_word(14'h0222, 0);
        run_sched("gap_wait", 0, 0);
`endif
        chk("gap_x", 32'(bus.x_out), 32'h0111);
        chk("gap_d", 32'(bus.d_out), 32'h0222);
        chk("gap_cnt", 32'(bus.frame_cnt), 32'd6);

        // Reset in the middle of UPDATE, tap 10.
        send_frame(14'h0155, 14'h0AAA, 0);
        run_sched("pre_rst", 0, N + 13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctl", 32'(obs()), 32'h0);
        chk("midrst_x", 32'(bus.x_out), 32'h0);
        chk("midrst_d", 32'(bus.d_out), 32'h0);
        chk("midrst_cnt", 32'(bus.frame_cnt), 32'h0);
        send_word(14'h0005, 0);
        send_word(14'h0006, 0);
        repeat (3) @(negedge clk);
        chk("midrst_nohdr_busy", 32'(bus.busy), 32'h0);
        chk("midrst_nohdr_x", 32'(bus.x_out), 32'h0);
        send_frame(14'h0007, 14'h0008, 1);
        run_sched("post_rst", 0, 0);
        chk("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);

        // Frame counter wrap from a preloaded 0xFFFF.
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        send_frame(14'h0009, 14'h000A, 0);
        run_sched("wrap", 0, 0);
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
